// File: rtl/if_stage.sv
// rtl/if_stage.sv - instruction fetch stage with program-loaded memory and IF/ID register
module if_stage #(
  parameter int          ADDR_W      = 8,
  parameter logic [31:0] RESET_PC    = 32'h0000_0000,
  parameter logic [5:0]  HALT_OPCODE = 6'b111111
) (
  input  logic              clock,
  input  logic              resetGral,
  input  logic              stall,
  input  logic              branchTaken,
  input  logic [31:0]       branchTarget,
  input  logic              progWrEn,
  input  logic [ADDR_W-1:0] progAddr,
  input  logic [31:0]       progData,
  output logic [31:0]       instruction,
  output logic [31:0]       pcPlus4,
  output logic              valid,
  output logic [31:0]       pc,
  output logic              halted
);

  typedef enum logic {RUN, HALTED} state_t;

  state_t      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] instr_q, instr_d;
  logic [31:0] pc_plus4_q, pc_plus4_d;
  logic        valid_q, valid_d;
  logic [31:0] fetch_word;

  logic [31:0] mem_q [0:(1<<ADDR_W)-1];

  // Asynchronous read sees the pre-edge contents, giving read-before-write on collisions.
  assign fetch_word = mem_q[pc_q[ADDR_W+1:2]];

  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    instr_d    = instr_q;
    pc_plus4_d = pc_plus4_q;
    valid_d    = valid_q;
    case (state_q)
      RUN: begin
        if (branchTaken) begin
          pc_d       = {branchTarget[31:2], 2'b00};
          instr_d    = 32'h0;
          pc_plus4_d = 32'h0;
          valid_d    = 1'b0;
        end else if (!stall) begin
          instr_d    = fetch_word;
          pc_plus4_d = pc_q + 32'd4;
          valid_d    = 1'b1;
          if (fetch_word[31:26] == HALT_OPCODE) begin
            state_d = HALTED;
          end else begin
            pc_d = pc_q + 32'd4;
          end
        end
      end
      HALTED: begin
        instr_d = 32'h0;
        valid_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clock) begin
    if (resetGral) begin
      state_q    <= RUN;
      pc_q       <= RESET_PC;
      instr_q    <= 32'h0;
      pc_plus4_q <= 32'h0;
      valid_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      instr_q    <= instr_d;
      pc_plus4_q <= pc_plus4_d;
      valid_q    <= valid_d;
    end
  end

  // Program writes are accepted in every state, reset included.
  always_ff @(posedge clock) begin
    if (progWrEn) begin
      mem_q[progAddr] <= progData;
    end
  end

  assign instruction = instr_q;
  assign pcPlus4     = pc_plus4_q;
  assign valid       = valid_q;
  assign pc          = pc_q;
  assign halted      = (state_q == HALTED);

endmodule

// File: tb/tb_if_stage.sv
// tb/tb_if_stage.sv - scoreboard bench for if_stage
module tb_if_stage;

  localparam int AW = 2;

  logic          clock = 1'b0;
  logic          resetGral = 1'b0;
  logic          stall = 1'b0;
  logic          branchTaken = 1'b0;
  logic [31:0]   branchTarget = 32'h0;
  logic          progWrEn = 1'b0;
  logic [AW-1:0] progAddr = '0;
  logic [31:0]   progData = 32'h0;
  logic [31:0]   instruction;
  logic [31:0]   pcPlus4;
  logic          valid;
  logic [31:0]   pc;
  logic          halted;

  if_stage #(.ADDR_W(AW)) dut (
    .clock(clock), .resetGral(resetGral), .stall(stall),
    .branchTaken(branchTaken), .branchTarget(branchTarget),
    .progWrEn(progWrEn), .progAddr(progAddr), .progData(progData),
    .instruction(instruction), .pcPlus4(pcPlus4), .valid(valid),
    .pc(pc), .halted(halted)
  );

  always #5 clock = ~clock;

  typedef struct packed {
    logic [31:0] ins;
    logic [31:0] p4;
    logic [31:0] pc;
    logic        v;
    logic        h;
  } exp_t;

  exp_t sb[$];
  int n_vec = 0;
  int n_miss = 0;

  // Reference state, written from the behavioural description only.
  logic [31:0] m_mem [0:3];
  logic [31:0] m_pc = 32'h0, m_ins = 32'h0, m_p4 = 32'h0;
  logic        m_v = 1'b0, m_h = 1'b0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_miss++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic model_step(input logic rst, input logic br, input logic st,
                            input logic [31:0] tgt, input logic wr,
                            input logic [AW-1:0] wa, input logic [31:0] wd);
    logic [31:0] w;
    exp_t e;
    if (rst) begin
      m_pc = 32'h0; m_ins = 32'h0; m_p4 = 32'h0; m_v = 1'b0; m_h = 1'b0;
    end else if (m_h) begin
      m_ins = 32'h0; m_v = 1'b0;
    end else if (br) begin
      m_pc = tgt & 32'hFFFF_FFFC; m_ins = 32'h0; m_p4 = 32'h0; m_v = 1'b0;
    end else if (!st) begin
      w = m_mem[m_pc[3:2]];
      m_ins = w; m_p4 = m_pc + 32'd4; m_v = 1'b1;
      if (w[31:26] == 6'b111111) m_h = 1'b1;
      else m_pc = m_pc + 32'd4;
    end
    if (wr) m_mem[wa] = wd;
    e.ins = m_ins; e.p4 = m_p4; e.pc = m_pc; e.v = m_v; e.h = m_h;
    sb.push_back(e);
  endtask

  task automatic cyc(input logic rst, input logic br, input logic st,
                     input logic [31:0] tgt, input logic wr,
                     input logic [AW-1:0] wa, input logic [31:0] wd);
    exp_t e;
    resetGral = rst; branchTaken = br; stall = st; branchTarget = tgt;
    progWrEn = wr; progAddr = wa; progData = wd;
    model_step(rst, br, st, tgt, wr, wa, wd);
    @(posedge clock);
    #1;
    if (sb.size() == 0) begin
      check_eq("scoreboard_empty", 32'd0, 32'd1);
    end else begin
      e = sb.pop_front();
      check_eq("instruction", instruction, e.ins);
      check_eq("pcPlus4", pcPlus4, e.p4);
      check_eq("pc", pc, e.pc);
      check_eq("valid", {31'h0, valid}, {31'h0, e.v});
      check_eq("halted", {31'h0, halted}, {31'h0, e.h});
    end
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) cyc(0, 0, 0, 32'h0, 0, '0, 32'h0);
  endtask

  initial begin
    // Load the program while held in reset.
    cyc(1, 0, 0, 0, 1, 2'd0, 32'h2040028A);
    cyc(1, 0, 0, 0, 1, 2'd1, 32'h20410003);
    cyc(1, 0, 0, 0, 1, 2'd2, 32'h00221004);
    cyc(1, 0, 0, 0, 1, 2'd3, 32'h00000000);
    check_eq("reset_pc", pc, 32'h0);

    run(1);
    check_eq("first_fetch", instruction, 32'h2040028A);
    for (int i = 0; i < 3; i++) cyc(0, 0, 1, 0, 0, '0, 0);
    check_eq("stall_hold_ins", instruction, 32'h2040028A);
    check_eq("stall_hold_pc", pc, 32'd4);
    run(1);
    check_eq("after_stall", instruction, 32'h20410003);
    run(2);
    check_eq("pc_after_four", pc, 32'd16);

    // Branch beats stall; misaligned target 6 lands on 4.
    cyc(1, 0, 0, 0, 0, '0, 0);
    run(2);
    cyc(0, 1, 1, 32'h0000_0006, 0, '0, 0);
    check_eq("branch_pc", pc, 32'd4);
    run(1);
    check_eq("branch_target_ins", instruction, 32'h20410003);
    check_eq("branch_target_p4", pcPlus4, 32'd8);

    // Redirect to the current PC refetches it after one bubble.
    cyc(0, 1, 0, 32'd8, 0, '0, 0);
    run(1);
    check_eq("refetch_same", instruction, 32'h00221004);

    // Write collision then halt on the new word.
    cyc(0, 1, 0, 32'd8, 0, '0, 0);
    cyc(0, 0, 0, 0, 1, 2'd2, 32'hFC00_0000);
    check_eq("collision_old", instruction, 32'h00221004);
    cyc(0, 1, 0, 32'd8, 0, '0, 0);
    run(1);
    check_eq("halt_word", instruction, 32'hFC00_0000);
    check_eq("halt_flag", {31'h0, halted}, 32'd1);
    cyc(0, 1, 0, 32'h40, 0, '0, 0);
    cyc(0, 0, 1, 0, 0, '0, 0);
    run(1);
    check_eq("halt_frozen_pc", pc, 32'd8);

    // Reset out of HALTED with stall and branch also raised; reload mem[3] meanwhile.
    cyc(1, 1, 1, 32'h20, 1, 2'd3, 32'h11111111);
    check_eq("halt_reset_pc", pc, 32'h0);
    cyc(0, 1, 0, 32'hFFFF_FFFC, 0, '0, 0);
    run(1);
    check_eq("wrap_ins", instruction, 32'h11111111);
    check_eq("wrap_p4", pcPlus4, 32'h0);
    check_eq("wrap_pc", pc, 32'h0);
    run(2);

    // Reset mid-stream; memory survives.
    cyc(1, 1, 1, 32'h8, 0, '0, 0);
    run(2);
    check_eq("mem_kept", instruction, 32'h20410003);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule

// File: doc/if_stage.md
Name: if_stage

Overview:
- Instruction-fetch stage and IF/ID pipeline register for the MIPS pipeline.
- Holds the PC and a word-addressed instruction memory that is loaded through a program port.
- Registers the fetched instruction and PC+4 into the `instruction`/`pcPlus4` outputs that drive the decode datapath's `instruction` input.
- Handles stall, branch/jump redirect with flush, and a HALT state.

Parameters:
- ADDR_W, 8, word-address bits of instruction memory (depth 2^ADDR_W words).
- RESET_PC, 32'h0000_0000, PC value after reset; byte address, bits [1:0] must be 0.
- HALT_OPCODE, 6'b111111, opcode field (bits [31:26]) that halts fetch.

Ports:
- clock, in, 1: single clock, rising edge.
- resetGral, in, 1: synchronous, active-high reset.
- stall, in, 1: hazard unit request to hold PC and the IF/ID register.
- branchTaken, in, 1: redirect request from a later stage.
- branchTarget, in, 32: byte address of the redirect target.
- progWrEn, in, 1: instruction memory write enable.
- progAddr, in, ADDR_W: word address for a memory write.
- progData, in, 32: word to write.
- instruction, out, 32: IF/ID registered instruction.
- pcPlus4, out, 32: IF/ID registered PC+4 of that instruction.
- valid, out, 1: instruction/pcPlus4 hold a real fetched instruction.
- pc, out, 32: current PC register (next fetch address).
- halted, out, 1: high while the FSM is in HALTED.

Behaviour:
- Clock and reset: one clock. Reset is synchronous and active-high. All state updates on the rising edge of `clock`.
- Reset (resetGral=1 at an edge):
  - pc=RESET_PC; instruction=0; pcPlus4=0; valid=0; halted=0; FSM=RUN.
  - Memory contents are not cleared.
  - Reset overrides every other input, including mid-stall, mid-branch and in HALTED.
- Memory:
  - Index = pc[ADDR_W+1:2]; upper PC bits are ignored, so fetch wraps modulo depth.
  - Asynchronous read, registered into IF/ID.
  - Write when progWrEn=1 at an edge: mem[progAddr]<=progData.
  - Same-edge write and fetch to the same word returns the OLD word (read-before-write).
  - Writes are accepted in every state, including during reset.
- FSM states: RUN, HALTED.
- RUN, priority from highest:
  1. branchTaken=1: pc<=branchTarget with bits [1:0] forced to 00; instruction<=0 (NOP); valid<=0; pcPlus4<=0. This applies even when stall=1, because branch wins over stall.
  2. stall=1: pc, instruction, pcPlus4 and valid all hold.
  3. Otherwise, let w=mem[index]:
     - instruction<=w; pcPlus4<=pc+4; valid<=1.
     - If w[31:26]==HALT_OPCODE: pc holds, FSM<=HALTED, halted<=1. The halt word itself is presented once with valid=1.
     - Else: pc<=pc+4. The add is mod 2^32, so 32'hFFFF_FFFC wraps to 0.
- HALTED:
  - pc holds; instruction<=0; valid<=0; pcPlus4 holds. branchTaken and stall are ignored.
  - Exited only by reset.
- Latency:
  - An instruction at address A is visible on `instruction` one edge after pc==A with no stall or branch.
  - After a branch, the first target instruction appears two edges after the branch edge; exactly one NOP bubble.
- Boundary rules:
  - Stall held for N cycles produces no duplicate and no lost instruction.
  - branchTaken with branchTarget==pc refetches the same address after the bubble.
  - Misaligned target 0x...06 → pc=0x...04.

Test Plan:
- Reset then load: mem[0]=32'h2040028A (addi r0,r2,650), mem[1]=32'h20410003 (addi r1,r2,3), mem[2]=32'h00221004, mem[3]=0; run 4 edges. Required: instruction=2040028A/pcPlus4=4, then 20410003/8, then 00221004/12, valid=1 throughout; pc=16 after edge 4.
- Stall: stall=1 for 3 edges after the first fetch. Required: instruction stays 2040028A, pc stays 4, valid stays 1; release gives 20410003 next with nothing skipped.
- Branch vs stall: at pc=8 assert branchTaken=1, stall=1, branchTarget=32'h0000_0006. Required next edge: pc=4, instruction=0, valid=0; following edge: instruction=20410003, pcPlus4=8.
- Halt: mem[2]=32'hFC00_0000. Required: after fetching it, valid=1 once, halted=1, pc=8 frozen; subsequent edges give instruction=0, valid=0 even with branchTaken=1; resetGral=1 returns pc=0, halted=0.
- Wrap and write collision:
  - ADDR_W=2, branch to 32'hFFFF_FFFC, mem[3]=32'h11111111. Required: fetch of 11111111 with pcPlus4=0, then pc wraps to 0.
  - Same-edge progWrEn to the fetched word. Required: old value is latched; the new value is seen on the next fetch of that word.
- Reset mid-stream: resetGral=1 while stall=1 and branchTaken=1. Required: pc=RESET_PC, instruction=0, valid=0 on that edge; memory contents preserved.
